// File: rtl/ofifo_drain_pkg.sv
// Shared types, default widths and lane helpers for the output-FIFO drain.
// Exports: state_t, COL/BW/PSUM_BW/NIJ_MAX/RD_LAT defaults, sext(), relu().
package ofifo_drain_pkg;

   localparam int COL     = 8;
   localparam int BW      = 16;
   localparam int PSUM_BW = 16;
   localparam int NIJ_MAX = 64;
   localparam int RD_LAT  = 2;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WAIT,
      DRAIN
   } state_t;

   // Sign-extend the low w bits of v to 32 bits.
   function automatic logic [31:0] sext(
      input logic [31:0] v,
      input int          w
   );
      logic signed [31:0] t;
      t = signed'(v << (32 - w));
      return 32'(t >>> (32 - w));
   endfunction

   // Clamp a w-bit two's-complement value at zero.
   function automatic logic [31:0] relu(
      input logic [31:0] v,
      input int          w
   );
      return v[w-1] ? 32'd0 : v;
   endfunction

endpackage

// File: rtl/acc_bank.sv
// Per-pixel accumulator register file: one write port (overwrite or add),
// one combinational read port. Ports: clk, we, add, waddr, wdata, raddr, rdata.
module acc_bank #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int nij_max = 64,
   parameter int aw      = 6
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic                   add,
   input  logic [aw-1:0]          waddr,
   input  logic [col*psum_bw-1:0] wdata,
   input  logic [aw-1:0]          raddr,
   output logic [col*psum_bw-1:0] rdata
);

   logic [col*psum_bw-1:0] mem [nij_max];
   logic [col*psum_bw-1:0] nxt;

   assign rdata = mem[raddr];

   // Accumulate reuses the read port; the top steers raddr to waddr
   // whenever it is not draining.
   always_comb begin
      nxt = wdata;
      for (int i = 0; i < col; i++) begin
         if (add)
            nxt[i*psum_bw +: psum_bw] =
               rdata[i*psum_bw +: psum_bw] + wdata[i*psum_bw +: psum_bw];
      end
   end

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= nxt;
   end

endmodule

// File: rtl/ofifo_psum_drain.sv
// Pops psum vectors from the output FIFO, accumulates them over cfg_kij
// passes of cfg_nij pixels, then streams ReLU'd results out over valid/ready.
// Ports: clk, reset (async, active-low), start, cfg_nij, cfg_kij,
//        ofifo_valid/ofifo_out/ofifo_rd, out_valid/out_ready/out_data/out_addr,
//        busy, done.
module ofifo_psum_drain
   import ofifo_drain_pkg::*;
#(
   parameter int col     = COL,
   parameter int bw      = BW,
   parameter int psum_bw = PSUM_BW,
   parameter int nij_max = NIJ_MAX,
   parameter int rd_lat  = RD_LAT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [6:0]             cfg_nij,
   input  logic [3:0]             cfg_kij,
   input  logic                   ofifo_valid,
   input  logic [bw*col-1:0]      ofifo_out,
   output logic                   ofifo_rd,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [psum_bw*col-1:0] out_data,
   output logic [5:0]             out_addr,
   output logic                   busy,
   output logic                   done
);

   localparam int WW = (rd_lat > 1) ? $clog2(rd_lat) : 1;

   state_t state, state_nx;

   logic [6:0]  nij_lim;
   logic [3:0]  kij_lim;
   logic [5:0]  nij_cnt;
   logic [3:0]  kij_cnt;
   logic [5:0]  drain_cnt;
   logic [WW-1:0] wait_cnt;

   logic [6:0] cfg_n_eff;
   logic [3:0] cfg_k_eff;
   logic wait_last;
   logic nij_last;
   logic kij_last;
   logic drain_last;
   logic capture;

   logic [psum_bw*col-1:0] ext_vec;
   logic [psum_bw*col-1:0] rd_vec;
   logic [5:0]             raddr;

   always_comb begin
      cfg_n_eff = cfg_nij;
      if (cfg_nij == 7'd0)
         cfg_n_eff = 7'd1;
      else if (cfg_nij > 7'(nij_max))
         cfg_n_eff = 7'(nij_max);
   end

   assign cfg_k_eff  = (cfg_kij == 4'd0) ? 4'd1 : cfg_kij;
   assign wait_last  = (wait_cnt == WW'(rd_lat - 1));
   assign nij_last   = ({1'b0, nij_cnt} == nij_lim - 7'd1);
   assign kij_last   = (kij_cnt == kij_lim - 4'd1);
   assign drain_last = ({1'b0, drain_cnt} == nij_lim - 7'd1);
   assign capture    = (state == WAIT) && wait_last;

   always_comb begin
      for (int i = 0; i < col; i++)
         ext_vec[i*psum_bw +: psum_bw] =
            psum_bw'(sext(32'(ofifo_out[i*bw +: bw]), bw));
   end

   assign raddr = (state == DRAIN) ? drain_cnt : nij_cnt;

   acc_bank #(
      .col     (col),
      .psum_bw (psum_bw),
      .nij_max (nij_max),
      .aw      (6)
   ) u_bank (
      .clk   (clk),
      .we    (capture),
      .add   (kij_cnt != 4'd0),
      .waddr (nij_cnt),
      .wdata (ext_vec),
      .raddr (raddr),
      .rdata (rd_vec)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      ofifo_rd  = 1'b0;
      out_valid = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start)
               state_nx = READ;
         end
         READ: begin
            if (ofifo_valid) begin
               ofifo_rd = 1'b1;
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (wait_last)
               state_nx = (nij_last && kij_last) ? DRAIN : READ;
         end
         DRAIN: begin
            out_valid = 1'b1;
            if (out_ready && drain_last) begin
               done     = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         nij_lim   <= 7'd0;
         kij_lim   <= 4'd0;
         nij_cnt   <= 6'd0;
         kij_cnt   <= 4'd0;
         drain_cnt <= 6'd0;
         wait_cnt  <= '0;
      end else begin
         if (state == IDLE && start) begin
            nij_lim   <= cfg_n_eff;
            kij_lim   <= cfg_k_eff;
            nij_cnt   <= 6'd0;
            kij_cnt   <= 4'd0;
            drain_cnt <= 6'd0;
         end
         if (state == READ)
            wait_cnt <= '0;
         if (state == WAIT)
            wait_cnt <= wait_cnt + 1'b1;
         if (capture) begin
            if (nij_last) begin
               nij_cnt <= 6'd0;
               kij_cnt <= kij_cnt + 4'd1;
            end else begin
               nij_cnt <= nij_cnt + 6'd1;
            end
         end
         if (state == DRAIN && out_ready)
            drain_cnt <= drain_cnt + 6'd1;
      end
   end

   always_comb begin
      out_data = '0;
      if (state == DRAIN) begin
         for (int i = 0; i < col; i++)
            out_data[i*psum_bw +: psum_bw] =
               psum_bw'(relu(32'(rd_vec[i*psum_bw +: psum_bw]), psum_bw));
      end
   end

   assign out_addr = (state == DRAIN) ? drain_cnt : 6'd0;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_ofifo_psum_drain.sv
// Scoreboard bench for ofifo_psum_drain: latency-accurate FIFO model,
// random/directed jobs, reference sums computed per pixel and lane.
module tb_ofifo_psum_drain;

   localparam int COL  = 8;
   localparam int BW   = 16;
   localparam int PW   = 16;
   localparam int NMAX = 64;
   localparam int RDL  = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic [6:0] cfg_nij = '0;
   logic [3:0] cfg_kij = '0;
   logic ofifo_valid = 1'b0;
   logic [BW*COL-1:0] ofifo_out = '0;
   logic ofifo_rd;
   logic out_valid;
   logic out_ready = 1'b1;
   logic [PW*COL-1:0] out_data;
   logic [5:0] out_addr;
   logic busy;
   logic done;

   always #5 clk = ~clk;

   ofifo_psum_drain #(
      .col(COL), .bw(BW), .psum_bw(PW), .nij_max(NMAX), .rd_lat(RDL)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .cfg_nij(cfg_nij), .cfg_kij(cfg_kij),
      .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_addr(out_addr),
      .busy(busy), .done(done)
   );

   typedef struct {
      logic [5:0]   addr;
      logic [127:0] data;
      bit           last;
   } exp_t;

   exp_t         exp_q[$];
   logic [127:0] fifo_q[$];
   logic [127:0] vecq[$];
   logic [127:0] pipe [RDL];

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   bit rd_pend = 0;
   int pops = 0;
   int starve_at = -1;
   int starve_left = 0;
   int ready_mode = 0;
   int pat = 0;
   int start_seq = 0;
   int start_ack = 0;
   logic [6:0] req_nij = '0;
   logic [3:0] req_kij = '0;
   bit inject = 0;
   bit injected = 0;
   int dones = 0;
   int last_rd = -100;
   bit prev_stall = 0;
   logic [5:0] prev_addr;
   logic [127:0] prev_data;
   exp_t e;

   function automatic void chk(string name, logic [127:0] act,
                               logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic logic [127:0] mk_all(int v);
      logic [127:0] r;
      for (int l = 0; l < COL; l++)
         r[16*l +: 16] = 16'(v);
      return r;
   endfunction

   // FIFO with RDL-cycle read latency, sink readiness, start pulses.
   always @(posedge clk) begin
      cyc++;
      #1;
      for (int k = RDL - 1; k > 0; k--)
         pipe[k] = pipe[k-1];
      if (rd_pend && fifo_q.size() > 0) begin
         pipe[0] = fifo_q.pop_front();
         pops++;
      end else begin
         pipe[0] = '0;
      end
      rd_pend = 0;
      ofifo_out = pipe[RDL-1];
      if (starve_left > 0 && pops == starve_at) begin
         ofifo_valid = 1'b0;
         starve_left--;
      end else begin
         ofifo_valid = (fifo_q.size() > 0);
      end
      case (ready_mode)
         0: out_ready = 1'b1;
         1: out_ready = 1'($urandom_range(0, 1));
         default: begin
            out_ready = (pat % 4 == 0) || (pat % 4 == 3);
            pat++;
         end
      endcase
      start = 1'b0;
      if (start_seq != start_ack) begin
         start = 1'b1;
         cfg_nij = req_nij;
         cfg_kij = req_kij;
         start_ack = start_seq;
      end else if (inject && !injected && out_valid) begin
         start = 1'b1;
         cfg_nij = 7'd3;
         cfg_kij = 4'd2;
         injected = 1;
      end
   end

   // Monitor: read protocol, stall stability, scoreboard pops.
   always @(negedge clk) begin
      if (reset) begin
         if (ofifo_rd) begin
            if (!ofifo_valid)
               chk("rd_without_valid", 1, 0);
            chk("rd_gap", (cyc - last_rd) >= RDL + 1, 1);
            last_rd = cyc;
            rd_pend = 1;
         end
         if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_addr", out_addr, prev_addr);
            chk("stall_data", out_data, prev_data);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("out_addr", out_addr, e.addr);
               chk("out_data", out_data, e.data);
               chk("done_on_last", done, e.last);
            end
            if (done)
               dones++;
         end else if (done) begin
            chk("done_without_accept", 1, 0);
         end
         prev_stall = out_valid && !out_ready;
         prev_addr = out_addr;
         prev_data = out_data;
      end else begin
         prev_stall = 0;
      end
   end

   task automatic run_job(int nij, int kij, int rmode, string tag);
      int n, k, s, t, d0;
      logic [15:0] w;
      logic [127:0] r, v;
      n = (nij == 0) ? 1 : ((nij > NMAX) ? NMAX : nij);
      k = (kij == 0) ? 1 : kij;
      while (vecq.size() < n * k)
         vecq.push_back({$urandom, $urandom, $urandom, $urandom});
      for (int i = 0; i < n; i++) begin
         r = '0;
         for (int l = 0; l < COL; l++) begin
            s = 0;
            for (int p = 0; p < k; p++) begin
               v = vecq[p*n + i];
               s += int'($signed(v[16*l +: 16]));
            end
            w = 16'(s);
            r[16*l +: 16] = w[15] ? 16'd0 : w;
         end
         exp_q.push_back('{6'(i), r, (i == n - 1)});
      end
      foreach (vecq[j])
         fifo_q.push_back(vecq[j]);
      vecq.delete();
      ready_mode = rmode;
      d0 = dones;
      req_nij = 7'(nij);
      req_kij = 4'(kij);
      start_seq++;
      t = 0;
      while (dones == d0 && t < 20000) begin
         @(posedge clk);
         t++;
      end
      chk({tag, "_done"}, dones == d0 + 1, 1);
      @(negedge clk);
      chk({tag, "_idle"}, busy, 0);
      chk({tag, "_sb_empty"}, exp_q.size(), 0);
      chk({tag, "_fifo_empty"}, fifo_q.size(), 0);
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_ofifo_rd"}, ofifo_rd, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_out_addr"}, out_addr, 0);
   endtask

   initial begin
      logic [127:0] v;
      int t;
      for (int k = 0; k < RDL; k++)
         pipe[k] = '0;
      repeat (3) @(posedge clk);
      #2;
      chk_zero("rst");
      @(negedge clk);
      reset = 1'b1;

      // single pass, lane0 = 5,-3,7,0
      for (int i = 0; i < 4; i++) begin
         v = {$urandom, $urandom, $urandom, $urandom};
         case (i)
            0: v[15:0] = 16'd5;
            1: v[15:0] = 16'hFFFD;
            2: v[15:0] = 16'd7;
            default: v[15:0] = 16'd0;
         endcase
         vecq.push_back(v);
      end
      run_job(4, 1, 0, "single");

      // three passes of two pixels
      vecq.push_back(mk_all(10));
      vecq.push_back(mk_all(-20));
      vecq.push_back(mk_all(-4));
      vecq.push_back(mk_all(5));
      vecq.push_back(mk_all(1));
      vecq.push_back(mk_all(6));
      run_job(2, 3, 0, "multi");

      // 0x7FFF + 1 wraps negative
      vecq.push_back(mk_all(32'h7FFF));
      vecq.push_back(mk_all(1));
      run_job(1, 2, 0, "wrap");

      // FIFO starvation mid-pass
      starve_at = pops + 5;
      starve_left = 20;
      run_job(6, 2, 0, "starve");

      run_job(5, 1, 2, "bp");
      run_job(0, 0, 1, "zero_cfg");
      run_job(100, 1, 1, "clamp");

      // start during DRAIN is ignored
      inject = 1;
      injected = 0;
      run_job(4, 2, 2, "inj");
      inject = 0;
      chk("inj_fired", injected, 1);
      repeat (3) @(negedge clk);
      chk("inj_ignored", busy, 0);
      run_job(3, 2, 0, "post_inj");

      // reset in WAIT
      for (int i = 0; i < 8; i++)
         fifo_q.push_back({$urandom, $urandom, $urandom, $urandom});
      req_nij = 7'd8;
      req_kij = 4'd1;
      start_seq++;
      t = 0;
      @(negedge clk);
      while (!ofifo_rd && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("rst_saw_rd", ofifo_rd, 1);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk_zero("midrst");
      fifo_q.delete();
      exp_q.delete();
      for (int k = 0; k < RDL; k++)
         pipe[k] = '0;
      repeat (2) @(posedge clk);
      rd_pend = 0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("after_rst_busy", busy, 0);
      run_job(3, 2, 0, "post_rst");

      for (int j = 0; j < 4; j++)
         run_job($urandom_range(1, 10), $urandom_range(1, 4), 1, "rand");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
